// File: rtl/rf_arb_pkg.sv
// Shared constants and FSM encoding for the register-file port arbiter.
// The optional ownership-lock feature is enabled with RF_ARB_LOCK_EN.
package rf_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int N = NREQ_DEF,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file write port / read mux among NREQ requesters with
// round-robin grant and 1-cycle read responses. Define RF_ARB_LOCK_EN to let
// a requester hold ownership across transactions.
module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [AW-1:0]     rf_raddr,
    input  logic [DW-1:0]     rf_rdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              locked
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    state_e          state_q, state_d;
    logic [PW-1:0]   own_q, own_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   sel_idx;
    logic            acc;
    logic            acc_rd;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grant is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        gnt_c   = '0;
        sel_idx = pick_idx;
`ifdef RF_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            sel_idx        = own_q;
            gnt_c[own_q]   = req_valid[own_q];
        end else begin
            gnt_c = pick_any ? pick_gnt : '0;
        end
`else
        gnt_c = pick_any ? pick_gnt : '0;
`endif
        if (!rst_n) gnt_c = '0;
    end

    assign acc      = |gnt_c;
    assign acc_rd   = acc & ~req_we[sel_idx];
    assign gnt      = gnt_c;
    assign rf_we    = acc & req_we[sel_idx];
    assign rf_waddr = req_addr[sel_idx*AW +: AW];
    assign rf_raddr = req_addr[sel_idx*AW +: AW];
    assign rf_wdata = req_wdata[sel_idx*DW +: DW];

    always_comb begin
        ptr_d = ptr_q;
        if (acc) ptr_d = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + 1'b1;
        rsp_valid_d = acc_rd ? gnt_c : '0;
        rsp_rdata_d = acc_rd ? rf_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            state_q     <= ST_IDLE;
            own_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            state_q     <= state_d;
            own_q       <= own_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef RF_ARB_LOCK_EN
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        case (state_q)
            ST_IDLE:   if (acc && req_lock[sel_idx]) begin
                           state_d = ST_LOCKED;
                           own_d   = sel_idx;
                       end
            ST_LOCKED: if (acc && !req_lock[own_q]) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end
`else
    logic unused_lock;
    assign unused_lock = ^{req_lock, state_q, own_q};

    always_comb begin
        state_d = ST_IDLE;
        own_d   = '0;
    end

    always_comb begin
        locked = 1'b0;
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small register-file model;
// lock checks follow RF_ARB_LOCK_EN.
module tb_regfile_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_we, req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic               rf_we, locked;
    logic [AW-1:0]      rf_waddr, rf_raddr;
    logic [DW-1:0]      rf_wdata, rf_rdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    regfile_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: unwritten address a reads 16'hA000 | a.
    logic [DW-1:0]       mem [16];
    logic [15:0]         wr_mask;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_mask <= '0;
        else if (rf_we) begin
            mem[rf_waddr]     <= rf_wdata;
            wr_mask[rf_waddr] <= 1'b1;
        end
    end
    assign rf_rdata = wr_mask[rf_raddr] ? mem[rf_raddr] : (16'hA000 | {12'h0, rf_raddr});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_lock[i]            = lk;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_we    = '1;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0);

        // Reset held with every requester valid.
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);

        // Release: all four read addr 3 continuously, round-robin from 0.
        rst_n  = 1'b1;
        req_we = '0;
        #1;
        chk("rr_raddr", 32'(rf_raddr), 32'h3);
        for (int k = 0; k <= 4; k++) begin
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk("rr_rf_we", 32'(rf_we), 32'h0);
            if (k > 0) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((k - 1) % 4)));
                chk("rr_rsp_rdata", 32'(rsp_rdata), 32'hA003);
            end
            tick();
        end

        // Requester 2 writes BEEF to addr 5 (ptr=1).
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(2, 1'b1, 1'b1, 1'b0, 4'd5, 16'hBEEF);
        #1;
        chk("wr_gnt", 32'(gnt), 32'h4);
        chk("wr_rf_we", 32'(rf_we), 32'h1);
        chk("wr_waddr", 32'(rf_waddr), 32'h5);
        chk("wr_wdata", 32'(rf_wdata), 32'hBEEF);
        tick();
        chk("wr_no_rsp", 32'(rsp_valid), 32'h0);
        chk("wr_rdata_hold", 32'(rsp_rdata), 32'hA003);

        // Requester 0 reads addr 5 back (ptr=3 wraps to 0).
        set_req(2, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0);
        #1;
        chk("rb_gnt", 32'(gnt), 32'h1);
        chk("rb_rf_we", 32'(rf_we), 32'h0);
        chk("rb_raddr", 32'(rf_raddr), 32'h5);
        tick();
        chk("rb_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rb_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("idle_rdata_hold", 32'(rsp_rdata), 32'hBEEF);

        // Requester 1 reads addr 7 with lock, requester 3 also requesting (ptr=1).
        set_req(1, 1'b1, 1'b0, 1'b1, 4'd7, 16'h0);
        set_req(3, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
        #1;
        chk("lk_first_gnt", 32'(gnt), 32'h2);
        tick();
        chk("lk_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lk_rsp_rdata", 32'(rsp_rdata), 32'hA007);
`ifdef RF_ARB_LOCK_EN
        chk("lk_locked", 32'(locked), 32'h1);
        // Owner idle: requester 3 must still stall.
        req_valid[1] = 1'b0;
        #1;
        chk("lk_stall_gnt", 32'(gnt), 32'h0);
        tick();
        chk("lk_still_locked", 32'(locked), 32'h1);
        chk("lk_stall_rsp", 32'(rsp_valid), 32'h0);
        // Owner issues its final transaction with lock dropped.
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
        #1;
        chk("lk_owner_gnt", 32'(gnt), 32'h2);
        tick();
        chk("lk_released", 32'(locked), 32'h0);
        #1;
        chk("lk_pass_gnt", 32'(gnt), 32'h8);
        // Re-lock by requester 1 (ptr=2 search 2,3,0,1), then reset mid-lock.
        req_valid[3] = 1'b0;
        req_lock[1]  = 1'b1;
        #1;
        chk("rl_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rl_locked", 32'(locked), 32'h1);
`else
        chk("nl_locked", 32'(locked), 32'h0);
        #1;
        chk("nl_next_gnt", 32'(gnt), 32'h8);
        tick();
        chk("nl_locked2", 32'(locked), 32'h0);
        chk("nl_rsp_valid", 32'(rsp_valid), 32'h8);
        // Requester 1 alone (ptr=0) so ptr becomes 2 before reset.
        req_valid[3] = 1'b0;
        #1;
        chk("nl_r1_gnt", 32'(gnt), 32'h2);
        tick();
        chk("nl_r1_locked", 32'(locked), 32'h0);
`endif
        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_locked", 32'(locked), 32'h0);
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_rf_we", 32'(rf_we), 32'h0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
        set_req(3, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
        #1;
        chk("ar_ptr0_gnt", 32'(gnt), 32'h2);
        tick();
        chk("ar_unlocked", 32'(locked), 32'h0);
        #1;
        chk("ar_next_gnt", 32'(gnt), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 The block SHALL expose parameter NREQ, default 4, number of requesters sharing the register-file port.
REQ-002 The block SHALL expose parameter DW, default 16, register data width.
REQ-003 The block SHALL expose parameter AW, default 4, register address width (16 registers).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  NREQ  per-requester request present.
REQ-007 req_we  input  NREQ  per-requester write (1) / read (0).
REQ-008 req_lock  input  NREQ  per-requester request to keep ownership after this transaction.
REQ-009 req_addr  input  NREQ*AW  packed register addresses, requester i at bits [i*AW +: AW].
REQ-010 req_wdata  input  NREQ*DW  packed write data, requester i at bits [i*DW +: DW].
REQ-011 gnt  output  NREQ  one-hot-or-zero grant; a transaction is accepted when req_valid[i] and gnt[i] are both high.
REQ-012 rf_we, rf_waddr, rf_wdata, rf_raddr  output  1/AW/DW/AW  register-file write port and read-mux select.
REQ-013 rf_rdata  input  DW  combinational read-mux output for rf_raddr.
REQ-014 rsp_valid  output  NREQ  one-hot-or-zero read-response strobe; rsp_rdata  output  DW  read data.
REQ-015 locked  output  1  high while ownership is held by a requester.

Function
REQ-016 gnt SHALL be combinational from req_valid, the round-robin pointer and lock state; at most one bit high per cycle.
REQ-017 Unlocked, the granted requester SHALL be the first with req_valid high searching from index ptr upward, wrapping NREQ-1 to 0.
REQ-018 On each accepted transaction by requester k, ptr SHALL update to (k+1) mod NREQ; with no acceptance ptr SHALL hold.
REQ-019 In an accept cycle rf_waddr/rf_raddr SHALL equal req_addr of k, rf_wdata req_wdata of k, and rf_we SHALL equal req_we[k]; otherwise rf_we SHALL be 0.
REQ-020 An accepted read SHALL register rf_rdata into rsp_rdata and assert rsp_valid[k] for exactly one cycle, one cycle after acceptance (latency 1); accepted writes produce no response.
REQ-021 rsp_rdata SHALL hold its last value when rsp_valid is all zero.
REQ-022 FSM states: IDLE (no owner), LOCKED (owner index own held); IDLE->LOCKED on acceptance with req_lock[k]=1, own<=k; LOCKED->IDLE on owner acceptance with req_lock[own]=0.
REQ-023 In LOCKED only gnt[own] SHALL be asserted, and only when req_valid[own] is high; other requesters stall even if the owner is idle.
REQ-024 A read and a write to the same address SHALL never coexist (single grant); back-to-back write-then-read to an address returns the new value.
REQ-025 locked SHALL be high exactly in state LOCKED.

Reset
REQ-026 On rst_n low: ptr=0, state=IDLE, own=0, rsp_valid=0, rsp_rdata=0, gnt=0 and rf_we=0 while asserted; reset mid-lock SHALL release ownership immediately.

Configuration
REQ-027 Macro RF_ARB_LOCK_EN SHALL enable the lock feature; when defined, REQ-022/023 apply.
REQ-028 Without RF_ARB_LOCK_EN, req_lock SHALL be ignored, state SHALL remain IDLE, and locked SHALL be tied 0.

Structure
REQ-029 Package rf_arb_pkg SHALL hold default NREQ/DW/AW constants and the FSM state encoding (ST_IDLE, ST_LOCKED).
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs request vector, ptr; outputs one-hot grant, index, any).

Verification
REQ-031 Reset: rst_n low with all req_valid=1 -> gnt=0, rf_we=0, rsp_valid=0; after release first grant goes to requester 0.
REQ-032 All four requesting reads of addr 3 continuously -> gnt sequence 0,1,2,3,0; each rsp_valid[k] one cycle after its grant with rf_rdata value.
REQ-033 Requester 2 writes 16'hBEEF to addr 5, requester 0 then reads addr 5 -> rf_we=1 with waddr 5 in write cycle; next read returns 16'hBEEF.
REQ-034 With RF_ARB_LOCK_EN: requester 1 read addr 7 with req_lock=1, requester 3 requesting -> requester 3 stalls until requester 1 issues transaction with req_lock=0; then grant passes to 2 or 3 per ptr.
REQ-035 Reset asserted while locked=1 -> locked=0 asynchronously; after release ptr=0 and arbitration unlocked.
REQ-036 Without RF_ARB_LOCK_EN, repeat REQ-034 stimulus -> requester 3 granted in the next cycle, locked stays 0.
